// File: rtl/sincronizador_vga.sv
// VGA timing generator: divides clk into a pixel tick and walks a horizontal/vertical
// raster, producing registered sync/blanking aligned with the pixel counters.
module sincronizador_vga #(
  parameter int TICK_DIV  = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       end_frame
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [9:0] H_TOTAL  = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] V_TOTAL  = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_tick;
  logic [9:0]    r_x, r_y;
  logic          r_hsync, r_vsync, r_video_on;

  logic [TW-1:0] w_tick_next;
  logic [9:0]    w_x_next, w_y_next;
  logic          w_tick, w_h_wrap, w_v_wrap;

  assign w_tick   = (r_tick == TICK_LAST);
  assign w_h_wrap = (r_x == H_TOTAL - 10'd1);
  assign w_v_wrap = (r_y == V_TOTAL - 10'd1);

  always_comb begin
    w_tick_next = w_tick ? '0 : r_tick + TW'(1);
    w_x_next    = r_x;
    w_y_next    = r_y;
    if (w_tick) begin
      w_x_next = w_h_wrap ? 10'd0 : r_x + 10'd1;
      if (w_h_wrap)
        w_y_next = w_v_wrap ? 10'd0 : r_y + 10'd1;
    end
  end

  // Sync and blanking are decoded from the next counts so that, once registered,
  // they describe the same pixel that pixel_x/pixel_y hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
    end else begin
      r_tick     <= w_tick_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_hsync    <= !((w_x_next >= HS_START) && (w_x_next <= HS_END));
      r_vsync    <= !((w_y_next >= VS_START) && (w_y_next <= VS_END));
      r_video_on <= (w_x_next < H_VIS) && (w_y_next < V_VIS);
    end
  end

  assign p_tick    = w_tick;
  assign pixel_x   = r_x;
  assign pixel_y   = r_y;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign video_on  = r_video_on;
  assign end_frame = w_tick && w_h_wrap && w_v_wrap;

endmodule

// File: tb/tb_sincronizador_vga.sv
// Scoreboard bench: the stimulus side tracks clocks since the last reset edge and
// pushes the expected raster state; a negedge monitor pops and compares.
module tb_sincronizador_vga;

  localparam int TD = 4;
  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 5, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT * TD;

  typedef struct packed {
    logic       pt;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       ef;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p_tick, hsync, vsync, video_on, end_frame;
  logic [9:0] pixel_x, pixel_y;

  sincronizador_vga #(
    .TICK_DIV(TD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y), .end_frame(end_frame)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   k      = 0;  // clk edges since the last reset edge

  // Raster position follows from elapsed clocks: pixels = k / TD, then line/frame by division.
  function automatic obs_t model(input int kk);
    obs_t o;
    int n, x, y;
    n    = kk / TD;
    x    = n % HT;
    y    = (n / HT) % VT;
    o.pt = ((kk % TD) == TD - 1);
    o.x  = 10'(x);
    o.y  = 10'(y);
    if (kk == 0) begin
      o.hs = 1'b1; o.vs = 1'b1; o.vo = 1'b0;
    end else begin
      o.hs = !(x >= HD + HF && x < HD + HF + HS);
      o.vs = !(y >= VD + VF && y < VD + VF + VS);
      o.vo = (x < HD) && (y < VD);
    end
    o.ef = o.pt && (x == HT - 1) && (y == VT - 1);
    return o;
  endfunction

  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk);
    k = reset ? 0 : k + 1;
    exp_q.push_back(model(k));
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Advance until the current state matches (pt, x, y), then reset on that edge.
  task automatic reset_at(input int tx, input int ty, input string name);
    obs_t cur;
    int   lim;
    lim = 0;
    cur = model(k);
    while (!(cur.pt && cur.x == 10'(tx) && cur.y == 10'(ty)) && lim < 2 * FRAME) begin
      step(1'b0);
      cur = model(k);
      lim++;
    end
    checks++;
    if (lim < 2 * FRAME) passes++;
    else $display("FAIL %s: target x=%0d y=%0d not reached within %0d clks", name, tx, ty, 2 * FRAME);
    step(1'b1);
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.pt = p_tick; a.hs = hsync; a.vs = vsync; a.vo = video_on;
      a.ef = end_frame; a.x = pixel_x; a.y = pixel_y;
      checks++;
      if (a === e) passes++;
      else $display("FAIL raster cyc=%0d: got pt=%b hs=%b vs=%b vo=%b ef=%b x=%0d y=%0d, want pt=%b hs=%b vs=%b vo=%b ef=%b x=%0d y=%0d",
                    cyc, a.pt, a.hs, a.vs, a.vo, a.ef, a.x, a.y,
                    e.pt, e.hs, e.vs, e.vo, e.ef, e.x, e.y);
    end
  end

  initial begin
    #1;
    // Reset held 3 clocks, then two full frames plus a margin.
    repeat (3) step(1'b1);
    run(2 * FRAME + 20);
    // Random reset pulses at arbitrary raster positions.
    repeat (20) begin
      run($urandom_range(1, 700));
      for (int i = $urandom_range(1, 3); i > 0; i--) step(1'b1);
    end
    // Reset coinciding with a frame wrap, then with a mid-frame tick.
    reset_at(HT - 1, VT - 1, "wrap_reset");
    run(FRAME + 10);
    reset_at(HD + 2, 3, "midframe_reset");
    run(FRAME + 10);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
